nibble_serial_adder: RTL

- Wide adder that processes one 4-bit lookahead slice per clock.
- Consumes the propagate/generate and carry-lookahead path (pgu + carry_gen) per nibble and forms the sum bits, i.e. the stage directly downstream of carry_gen.
- Carry-out of each slice is registered and fed back as carry-in of the next, giving a small-area WIDTH-bit adder.
- Used by the datapath wherever a full-width parallel CLA is too large.

---
 rtl/nibble_serial_adder_pkg.sv | 18 +
 rtl/carry_gen.sv | 16 +
 rtl/nibble_serial_adder_cla.sv | 34 +++
 rtl/pgu.sv | 12 +
 rtl/nibble_serial_adder.sv | 159 +++++++++++++++
 5 files changed

// File: rtl/nibble_serial_adder_pkg.sv
// Shared definitions for the nibble-serial adder: slice width, FSM states and
// the index-width helper.
package nibble_serial_adder_pkg;

  localparam int NIBBLE_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // Index counter needs at least one bit even when there is a single slice.
  function automatic int idx_width(input int nibbles);
    return (nibbles <= 1) ? 1 : $clog2(nibbles);
  endfunction

endpackage

// File: rtl/carry_gen.sv
// Four-bit carry-lookahead generator; c[i] is the carry out of bit i.
module carry_gen (
  input  logic [3:0] p,
  input  logic [3:0] g,
  input  logic       cin,
  output logic [3:0] c
);

  assign c[0] = g[0] | (p[0] & cin);
  assign c[1] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
  assign c[2] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
              | (p[2] & p[1] & p[0] & cin);
  assign c[3] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
              | (p[3] & p[2] & p[1] & g[0]) | (p[3] & p[2] & p[1] & p[0] & cin);

endmodule

// File: rtl/nibble_serial_adder_cla.sv
// Combinational 4-bit CLA slice (cla_nibble_slice): pgu + carry_gen + sum XOR.
import nibble_serial_adder_pkg::*;

module cla_nibble_slice (
  input  logic [NIBBLE_W-1:0] a4,
  input  logic [NIBBLE_W-1:0] b4,
  input  logic                cin,
  output logic [NIBBLE_W-1:0] s4,
  output logic [NIBBLE_W-1:0] c4,
  output logic                cout
);

  logic [NIBBLE_W-1:0] p;
  logic [NIBBLE_W-1:0] g;

  pgu u_pgu (
    .a (a4),
    .b (b4),
    .p (p),
    .g (g)
  );

  carry_gen u_carry_gen (
    .p   (p),
    .g   (g),
    .cin (cin),
    .c   (c4)
  );

  // Each sum bit sees the carry into its own position.
  assign s4   = p ^ {c4[NIBBLE_W-2:0], cin};
  assign cout = c4[NIBBLE_W-1];

endmodule

// File: rtl/pgu.sv
// Propagate/generate unit for one 4-bit slice.
module pgu (
  input  logic [3:0] a,
  input  logic [3:0] b,
  output logic [3:0] p,
  output logic [3:0] g
);

  assign p = a ^ b;
  assign g = a & b;

endmodule

// File: rtl/nibble_serial_adder.sv
// WIDTH-bit adder that resolves one 4-bit lookahead slice per clock.
// Define NIBBLE_SERIAL_ADDER_OVERFLOW_EN to add the two's-complement ovf output.
import nibble_serial_adder_pkg::*;

module nibble_serial_adder #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             busy
`ifdef NIBBLE_SERIAL_ADDER_OVERFLOW_EN
  ,
  output logic             ovf
`endif
);

  localparam int NIBBLES = WIDTH / NIBBLE_W;
  localparam int IW      = idx_width(NIBBLES);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d;
  logic [IW-1:0]    idx_q, idx_d;

  logic [NIBBLE_W-1:0] a_nib;
  logic [NIBBLE_W-1:0] b_nib;
  logic [NIBBLE_W-1:0] slice_s;
  logic [NIBBLE_W-1:0] slice_c;
  logic                slice_cout;
  logic                last_nib;

  always_comb begin
    a_nib = '0;
    b_nib = '0;
    for (int i = 0; i < NIBBLES; i++) begin
      if (idx_q == IW'(i)) begin
        a_nib = a_q[i*NIBBLE_W +: NIBBLE_W];
        b_nib = b_q[i*NIBBLE_W +: NIBBLE_W];
      end
    end
  end

  cla_nibble_slice u_slice (
    .a4   (a_nib),
    .b4   (b_nib),
    .cin  (carry_q),
    .s4   (slice_s),
    .c4   (slice_c),
    .cout (slice_cout)
  );

  assign last_nib = (idx_q == IW'(NIBBLES - 1));

`ifdef NIBBLE_SERIAL_ADDER_OVERFLOW_EN
  logic ovf_q, ovf_d;
`else
  logic unused_slice_c;
  assign unused_slice_c = ^slice_c;
`endif

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    idx_d   = idx_q;
`ifdef NIBBLE_SERIAL_ADDER_OVERFLOW_EN
    ovf_d   = ovf_q;
`endif
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d     = a;
          b_d     = b;
          carry_d = cin;
          idx_d   = '0;
          sum_d   = '0;
          cout_d  = 1'b0;
`ifdef NIBBLE_SERIAL_ADDER_OVERFLOW_EN
          ovf_d   = 1'b0;
`endif
          state_d = RUN;
        end
      end
      RUN: begin
        for (int i = 0; i < NIBBLES; i++) begin
          if (idx_q == IW'(i)) sum_d[i*NIBBLE_W +: NIBBLE_W] = slice_s;
        end
        carry_d = slice_cout;
        // Index is held on the final slice so it never wraps mid-transaction.
        if (last_nib) begin
          cout_d  = slice_cout;
`ifdef NIBBLE_SERIAL_ADDER_OVERFLOW_EN
          ovf_d   = slice_c[NIBBLE_W-2] ^ slice_c[NIBBLE_W-1];
`endif
          state_d = DONE;
        end else begin
          idx_d = idx_q + IW'(1);
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      idx_q   <= '0;
`ifdef NIBBLE_SERIAL_ADDER_OVERFLOW_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      idx_q   <= idx_d;
`ifdef NIBBLE_SERIAL_ADDER_OVERFLOW_EN
      ovf_q   <= ovf_d;
`endif
    end
  end

  // Operand registers only load at acceptance, so they carry no reset.
  always_ff @(posedge clk) begin
    a_q <= a_d;
    b_q <= b_d;
  end

  assign in_ready  = (state_q == IDLE);
  assign busy      = (state_q == RUN);
  assign out_valid = (state_q == DONE);
  assign sum       = sum_q;
  assign cout      = cout_q;
`ifdef NIBBLE_SERIAL_ADDER_OVERFLOW_EN
  assign ovf       = ovf_q;
`endif

endmodule
